// File: rtl/slow_to_fast_capture.sv
// Captures a slow-domain sample bus into the clk domain on selected edges of a
// synchronised slow strobe, buffering samples in a small FIFO with overflow flag.
module slow_to_fast_capture #(
    parameter int WIDTH       = 12,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0,
    parameter int DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       slow_clk,
    input  logic [WIDTH-1:0]           d,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = $clog2(SYNC_STAGES+1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic                   armed_q, armed_d;
    logic [AW-1:0]          arm_cnt_q, arm_cnt_d;
    logic [WIDTH-1:0]       q_q, q_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [WIDTH-1:0]       mem_q [DEPTH];

    logic rise, fall, edge_hit, capture;
    logic full, not_empty, do_pop, do_push, drop;

    // Handshake: a word leaves the FIFO on every clk edge where out_valid and
    // out_ready are both high; out_data is held stable while out_valid waits.
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], slow_clk};
        hist_d    = sync_q[SYNC_STAGES-1];
        rise      = sync_q[SYNC_STAGES-1] & ~hist_q;
        fall      = ~sync_q[SYNC_STAGES-1] & hist_q;
        case (EDGE_MODE)
            0:       edge_hit = rise;
            1:       edge_hit = fall;
            default: edge_hit = rise | fall;
        endcase
        capture   = edge_hit & armed_q;

        // Hold off events until the chain has flushed its post-reset contents.
        arm_cnt_d = arm_cnt_q;
        armed_d   = armed_q;
        if (!armed_q) begin
            if (arm_cnt_q == AW'(SYNC_STAGES)) armed_d = 1'b1;
            else                               arm_cnt_d = arm_cnt_q + AW'(1);
        end

        not_empty = (count_q != '0);
        full      = (count_q == CW'(DEPTH));
        do_pop    = not_empty & out_ready;
        do_push   = capture & (~full | do_pop);
        drop      = capture & full & ~do_pop;

        q_d        = capture ? d : q_q;
        wr_ptr_d   = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        overflow_d = overflow_q | drop;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= '0;
            hist_q     <= 1'b0;
            armed_q    <= 1'b0;
            arm_cnt_q  <= '0;
            q_q        <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            hist_q     <= hist_d;
            armed_q    <= armed_d;
            arm_cnt_q  <= arm_cnt_d;
            q_q        <= q_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // When full with a same-cycle pop, wr_ptr equals rd_ptr: the freed head
    // slot is reused for the new tail entry.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= d;
    end

    assign q         = q_q;
    assign out_valid = not_empty;
    assign out_data  = not_empty ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_slow_to_fast_capture.sv
// Scoreboard bench for slow_to_fast_capture: a rising-edge and a both-edge
// instance share stimulus and are checked against a queue-based model.
module tb_slow_to_fast_capture;
    localparam int WIDTH = 12;
    localparam int SYNC  = 2;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic             clk, reset, slow_clk, out_ready;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q_w [2];
    logic [WIDTH-1:0] out_data_w [2];
    logic             out_valid_w [2];
    logic             overflow_w [2];
    logic [CW-1:0]    count_w [2];

    int checks = 0;
    int errors = 0;

    int               since_rst;
    int               cnt [2];
    logic [WIDTH-1:0] mq [2];
    bit               ovf [2];
    logic [WIDTH-1:0] exp_q [2][$];
    int               pend_due [$];
    logic [WIDTH-1:0] pend_data [$];
    bit               pend_rise [$];

    slow_to_fast_capture #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .EDGE_MODE(0), .DEPTH(DEPTH)) dut_rise (
        .clk(clk), .reset(reset), .slow_clk(slow_clk), .d(d), .q(q_w[0]),
        .out_data(out_data_w[0]), .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .count(count_w[0]), .overflow(overflow_w[0])
    );

    slow_to_fast_capture #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .EDGE_MODE(2), .DEPTH(DEPTH)) dut_both (
        .clk(clk), .reset(reset), .slow_clk(slow_clk), .d(d), .q(q_w[1]),
        .out_data(out_data_w[1]), .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .count(count_w[1]), .overflow(overflow_w[1])
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        #25;
        forever #50 clk = ~clk;
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=0x%0h expected=0x%0h at %0t", name, idx, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            cnt[i] = 0;
            mq[i]  = '0;
            ovf[i] = 1'b0;
            exp_q[i].delete();
        end
        pend_due.delete();
        pend_data.delete();
        pend_rise.delete();
    endtask

    // Reference model: a slow edge made after reset release is captured
    // SYNC+1 edges later, provided that edge is at least SYNC+2 edges after release.
    initial begin : model
        bit               cap_any, is_rise, pop, cap;
        logic [WIDTH-1:0] cd;
        since_rst = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                since_rst = 0;
            end else begin
                since_rst++;
                cap_any = 1'b0;
                is_rise = 1'b0;
                cd      = '0;
                if (pend_due.size() > 0 && pend_due[0] == since_rst) begin
                    cap_any = 1'b1;
                    is_rise = pend_rise.pop_front();
                    cd      = pend_data.pop_front();
                    void'(pend_due.pop_front());
                end
                for (int i = 0; i < 2; i++) begin
                    pop = (cnt[i] > 0) && out_ready;
                    cap = cap_any && (i == 1 || is_rise) && (since_rst >= SYNC + 2);
                    if (cap) begin
                        mq[i] = cd;
                        if (cnt[i] < DEPTH || pop) begin
                            exp_q[i].push_back(cd);
                            cnt[i]++;
                        end else begin
                            ovf[i] = 1'b1;
                        end
                    end
                    if (pop) cnt[i]--;
                end
            end
        end
    end

    // monitor / scoreboard
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!reset) begin
                for (int i = 0; i < 2; i++) begin
                    chk("count", i, 32'(count_w[i]), 32'(cnt[i]));
                    chk("out_valid", i, 32'(out_valid_w[i]), 32'(cnt[i] != 0));
                    chk("q", i, 32'(q_w[i]), 32'(mq[i]));
                    chk("overflow", i, 32'(overflow_w[i]), 32'(ovf[i]));
                    if (cnt[i] == 0)
                        chk("out_data_empty", i, 32'(out_data_w[i]), 0);
                    else if (exp_q[i].size() > 0)
                        chk("out_data", i, 32'(out_data_w[i]), 32'(exp_q[i][0]));
                    if (out_valid_w[i] && out_ready && exp_q[i].size() > 0)
                        void'(exp_q[i].pop_front());
                end
            end
        end
    end

    // driver tasks: inputs change 20 time units after each rising clk edge
    task automatic step();
        @(posedge clk);
        #20;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) step();
    endtask

    task automatic toggle(input logic [WIDTH-1:0] val);
        d        = val;
        slow_clk = ~slow_clk;
        pend_due.push_back(since_rst + SYNC + 1);
        pend_data.push_back(val);
        pend_rise.push_back(slow_clk);
    endtask

    task automatic rise_cap(input logic [WIDTH-1:0] val, input int gap);
        if (slow_clk) begin
            toggle(d);
            wait_cyc(gap);
        end
        toggle(val);
        wait_cyc(gap);
    endtask

    task automatic async_reset();
        #10;
        reset = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_q", i, 32'(q_w[i]), 0);
            chk("rst_out_data", i, 32'(out_data_w[i]), 0);
            chk("rst_out_valid", i, 32'(out_valid_w[i]), 0);
            chk("rst_count", i, 32'(count_w[i]), 0);
            chk("rst_overflow", i, 32'(overflow_w[i]), 0);
        end
    endtask

    initial begin : driver
        logic [WIDTH-1:0] fill_v [5];
        logic [WIDTH-1:0] full_v [4];
        logic [WIDTH-1:0] new_v;
        int               g;
        fill_v = '{12'hEFF, 12'hEAE, 12'hAAA, 12'h123, 12'h456};
        reset = 1'b1; slow_clk = 1'b0; d = 12'hEFF; out_ready = 1'b0;
        model_reset();
        #250 reset = 1'b0;
        step();

        // basic capture and latency
        out_ready = 1'b1;
        toggle(12'hEFF);
        wait_cyc(SYNC);
        chk("latency_early", 0, 32'(q_w[0]), 0);
        wait_cyc(1);
        chk("latency_q", 0, 32'(q_w[0]), 'hEFF);
        chk("latency_valid", 0, 32'(out_valid_w[0]), 1);
        wait_cyc(1);
        chk("popped_valid", 0, 32'(out_valid_w[0]), 0);
        chk("popped_count", 0, 32'(count_w[0]), 0);
        wait_cyc(1);
        repeat (3) rise_cap(WIDTH'($urandom_range(0, 4095)), 5);

        // fill, overflow, drain
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rise_cap(fill_v[k], 5);
            chk("fill_count", 0, 32'(count_w[0]), (k < 4) ? k + 1 : 4);
        end
        chk("fill_overflow", 0, 32'(overflow_w[0]), 1);
        chk("fill_q", 0, 32'(q_w[0]), 'h456);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain", 0, 32'(out_data_w[0]), 32'(fill_v[k]));
            step();
        end
        chk("drained_valid", 0, 32'(out_valid_w[0]), 0);

        // count 3 with sticky overflow, then asynchronous reset
        out_ready = 1'b0;
        repeat (3) rise_cap(WIDTH'($urandom_range(0, 4095)), 5);
        chk("pre_rst_count", 0, 32'(count_w[0]), 3);
        chk("pre_rst_overflow", 0, 32'(overflow_w[0]), 1);
        async_reset();
        slow_clk = 1'b1;
        wait_cyc(2);
        reset = 1'b0;

        // slow_clk high at reset release
        wait_cyc(8);
        for (int i = 0; i < 2; i++) begin
            chk("hi_rel_q", i, 32'(q_w[i]), 0);
            chk("hi_rel_count", i, 32'(count_w[i]), 0);
        end
        toggle(12'h3C3);
        wait_cyc(5);
        chk("fall_q_rise_mode", 0, 32'(q_w[0]), 0);
        chk("fall_q_both_mode", 1, 32'(q_w[1]), 'h3C3);
        toggle(12'h5A5);
        wait_cyc(5);
        chk("first_rise_q", 0, 32'(q_w[0]), 'h5A5);
        chk("first_rise_count", 0, 32'(count_w[0]), 1);
        chk("both_edges_count", 1, 32'(count_w[1]), 2);
        out_ready = 1'b1;
        wait_cyc(3);

        // full with simultaneous pop and push
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            full_v[k] = WIDTH'($urandom_range(0, 4095));
            rise_cap(full_v[k], 5);
        end
        chk("full_count", 0, 32'(count_w[0]), 4);
        toggle(d);
        wait_cyc(5);
        new_v = WIDTH'($urandom_range(0, 4095));
        toggle(new_v);
        wait_cyc(SYNC);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pushpop_count", 0, 32'(count_w[0]), 4);
        chk("pushpop_overflow", 0, 32'(overflow_w[0]), 0);
        chk("pushpop_q", 0, 32'(q_w[0]), 32'(new_v));
        wait_cyc(3);
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            chk("pushpop_drain", 0, 32'(out_data_w[0]), 32'(full_v[k]));
            step();
        end
        chk("pushpop_tail", 0, 32'(out_data_w[0]), 32'(new_v));
        step();

        // randomized traffic with random backpressure
        repeat (40) begin
            toggle(WIDTH'($urandom_range(0, 4095)));
            g = $urandom_range(SYNC + 2, 9);
            repeat (g) begin
                out_ready = ($urandom_range(0, 2) != 0);
                step();
            end
        end
        out_ready = 1'b1;
        wait_cyc(12);
        for (int i = 0; i < 2; i++) chk("final_count", i, 32'(count_w[i]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
